// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared encodings and defaults for the RTC bus arbiter.
// The optional build macro RTC_ARB_FIXED_PRIO_EN (used in rr_arbiter)
// switches arbitration from round-robin to fixed lowest-index priority.
package rtc_bus_pkg;

  // Bus-cycle FSM encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    AREC = 3'd2,
    DATA = 3'd3,
    REC  = 3'd4
  } state_e;

  // All RTC strobes are active low.
  localparam logic STROBE_IDLE = 1'b1;
  localparam logic STROBE_ACT  = 1'b0;

  // Default phase lengths in clock cycles.
  localparam int TPH_DEF  = 4;
  localparam int TREC_DEF = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational winner selection for the RTC bus arbiter.
// Default: round-robin, first set request at or after ptr (wrapping).
// With RTC_ARB_FIXED_PRIO_EN defined: lowest index always wins, ptr ignored.
module rr_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic found;

`ifdef RTC_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest set index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = IW'(k);
      end
    end
  end
`else
  // Scan from the pointer upward, wrapping, and take the first set request.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end
`endif

  assign any = |req;
  assign gnt = found ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the multiplexed RTC address/data bus between NREQ
// requesters. Each granted request runs ADDR, AREC, DATA (TPH cycles each)
// and REC (TREC cycles); done pulses on the last REC cycle.
// Build option: RTC_ARB_FIXED_PRIO_EN selects fixed priority in rr_arbiter.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TPH  = TPH_DEF,
  parameter int TREC = TREC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   rw,
  input  logic [NREQ*8-1:0] addr,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  input  logic [7:0]        ADin,
  output logic [7:0]        ADout,
  output logic              ad_oe,
  output logic              ad,
  output logic              wr,
  output logic              rd,
  output logic              cs
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(max_int(TPH, TREC)) + 1;
  localparam logic [CW-1:0] PH_LAST  = CW'(TPH - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(TREC - 1);

  // Per-requester views of the flat address/data buses.
  logic [7:0] addr_arr  [NREQ];
  logic [7:0] wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = addr[8*gi +: 8];
    assign wdata_arr[gi] = wdata[8*gi +: 8];
  end

  // FSM and latched-transaction state.
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] sel_q, sel_d;
  logic            rw_lat_q, rw_lat_d;
  logic [7:0]      addr_lat_q, addr_lat_d;
  logic [7:0]      wdata_lat_q, wdata_lat_d;
  logic [7:0]      rdata_q, rdata_d;

  // Registered outputs.
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [7:0]      adout_q, adout_d;
  logic            ad_oe_q, ad_oe_d;
  logic            ad_q, ad_d;
  logic            wr_q, wr_d;
  logic            rd_q, rd_d;
  logic            cs_q, cs_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // State register: FSM state, phase counter and latched transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      sel_q       <= '0;
      rw_lat_q    <= 1'b0;
      addr_lat_q  <= '0;
      wdata_lat_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      sel_q       <= sel_d;
      rw_lat_q    <= rw_lat_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next state: inputs are only looked at in IDLE; each phase reloads the counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    sel_d       = sel_q;
    rw_lat_d    = rw_lat_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d     = ADDR;
          cnt_d       = PH_LAST;
          win_d       = arb_idx;
          sel_d       = arb_gnt;
          rw_lat_d    = rw[arb_idx];
          addr_lat_d  = addr_arr[arb_idx];
          wdata_lat_d = wdata_arr[arb_idx];
        end
      end
      ADDR: begin
        if (cnt_q == '0) begin
          state_d = AREC;
          cnt_d   = PH_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      AREC: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = PH_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          // Capture the RTC byte at the end of the read strobe.
          if (!rw_lat_q) begin
            rdata_d = ADin;
          end
          state_d = REC;
          cnt_d   = REC_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      REC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          sel_d   = '0;
          ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every bus signal leaves a flop.
  always_comb begin
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    adout_d = '0;
    ad_oe_d = 1'b0;
    ad_d    = STROBE_IDLE;
    wr_d    = STROBE_IDLE;
    rd_d    = STROBE_IDLE;
    cs_d    = STROBE_IDLE;
    case (state_d)
      ADDR: begin
        cs_d    = STROBE_ACT;
        ad_d    = STROBE_ACT;
        wr_d    = STROBE_ACT;
        ad_oe_d = 1'b1;
        adout_d = addr_lat_d;
      end
      AREC: begin
        cs_d    = STROBE_ACT;
        ad_d    = STROBE_ACT;
        ad_oe_d = 1'b1;
        adout_d = addr_lat_d;
      end
      DATA: begin
        cs_d = STROBE_ACT;
        if (rw_lat_d) begin
          wr_d    = STROBE_ACT;
          ad_oe_d = 1'b1;
          adout_d = wdata_lat_d;
        end else begin
          rd_d = STROBE_ACT;
        end
      end
      REC: begin
        if (cnt_d == '0) begin
          done_d = sel_d;
        end
      end
      default: ;
    endcase
    if (state_d != IDLE) begin
      busy_d = 1'b1;
      gnt_d  = sel_d;
    end
  end

  // Output registers; reset drives the bus to idle levels immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      adout_q <= '0;
      ad_oe_q <= 1'b0;
      ad_q    <= STROBE_IDLE;
      wr_q    <= STROBE_IDLE;
      rd_q    <= STROBE_IDLE;
      cs_q    <= STROBE_IDLE;
    end else begin
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      adout_q <= adout_d;
      ad_oe_q <= ad_oe_d;
      ad_q    <= ad_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign ADout = adout_q;
  assign ad_oe = ad_oe_q;
  assign ad    = ad_q;
  assign wr    = wr_q;
  assign rd    = rd_q;
  assign cs    = cs_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: a transaction-offset model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_rtc_bus_arbiter;

  localparam int NREQ = 4;
  localparam int TPH  = 4;
  localparam int TREC = 4;
  localparam int L    = 3*TPH + TREC;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req   = '0;
  logic [NREQ-1:0]   rw    = '0;
  logic [NREQ*8-1:0] addr  = '0;
  logic [NREQ*8-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rdata, ADin, ADout;
  logic              busy, ad_oe, ad, wr, rd, cs;
  logic [7:0]        rtc_byte = 8'h00;

  // Second instance with short phases.
  logic [NREQ-1:0]   req2   = '0;
  logic [NREQ-1:0]   rw2    = '0;
  logic [NREQ*8-1:0] addr2  = '0;
  logic [NREQ*8-1:0] wdata2 = '0;
  logic [NREQ-1:0]   gnt2, done2;
  logic [7:0]        rdata2, ADout2;
  logic              busy2, ad_oe2, ad2, wr2, rd2, cs2;

  int n_cmp = 0;
  int n_fail = 0;
  int n_print = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  // RTC model: drives its byte while the read strobe is low.
  assign ADin = rd ? 8'h00 : rtc_byte;

  rtc_bus_arbiter #(.NREQ(NREQ), .TPH(TPH), .TREC(TREC)) u_dut (
    .clock(clock), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .ADin(ADin), .ADout(ADout),
    .ad_oe(ad_oe), .ad(ad), .wr(wr), .rd(rd), .cs(cs)
  );

  rtc_bus_arbiter #(.NREQ(NREQ), .TPH(1), .TREC(2)) u_dut2 (
    .clock(clock), .reset(reset), .req(req2), .rw(rw2), .addr(addr2), .wdata(wdata2),
    .gnt(gnt2), .done(done2), .rdata(rdata2), .busy(busy2), .ADin(8'h00), .ADout(ADout2),
    .ad_oe(ad_oe2), .ad(ad2), .wr(wr2), .rd(rd2), .cs(cs2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef RTC_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  // Transaction-level model: a transaction is a run of L cycles indexed by offset.
  bit         m_act = 0;
  int         m_off = 0;
  int         m_win = 0;
  int         m_ptr = 0;
  bit         m_rw = 0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [29:0] e_vec, g_vec;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_act = 0; m_ptr = 0; m_rdata = '0;
    end else if (!m_act) begin
      if (req != '0) begin
        m_win = pick(req, m_ptr);
        m_act = 1; m_off = 0;
        m_rw = rw[m_win];
        m_addr = addr[8*m_win +: 8];
        m_wdata = wdata[8*m_win +: 8];
      end
    end else begin
      if (m_off == 3*TPH - 1 && !m_rw) m_rdata = ADin;
      m_off++;
      if (m_off == L) begin
        m_act = 0;
        m_ptr = (m_win + 1) % NREQ;
      end
    end
    #1;
    begin
      logic [3:0] eg, ed; logic eb, eoe, ead, ewr, erd, ecs; logic [7:0] eo;
      eg = '0; ed = '0; eb = 0; eoe = 0; ead = 1; ewr = 1; erd = 1; ecs = 1; eo = '0;
      if (m_act) begin
        eb = 1; eg = 4'(1 << m_win);
        if (m_off < TPH) begin
          ecs = 0; ead = 0; ewr = 0; eoe = 1; eo = m_addr;
        end else if (m_off < 2*TPH) begin
          ecs = 0; ead = 0; eoe = 1; eo = m_addr;
        end else if (m_off < 3*TPH) begin
          ecs = 0;
          if (m_rw) begin ewr = 0; eoe = 1; eo = m_wdata; end
          else erd = 0;
        end else if (m_off == L - 1) begin
          ed = eg;
        end
      end
      e_vec = {eg, ed, m_rdata, eb, eo, eoe, ead, ewr, erd, ecs};
      g_vec = {gnt, done, rdata, busy, ADout, ad_oe, ad, wr, rd, cs};
      n_cmp++;
      if (g_vec !== e_vec) begin
        n_fail++;
        if (n_print < 10) begin
          n_print++;
          $display("FAIL cycle-model cyc=%0d got %h expected %h (gnt,done,rdata,busy,ADout,oe,ad,wr,rd,cs)",
                   cyc, g_vec, e_vec);
        end
      end
    end
  end

  // Per-cycle samples of a 16-cycle transaction window.
  logic [15:0] s_wr, s_ad, s_cs, s_rd, s_oe, s_dn;
  logic [7:0]  s_out [16];
  logic [3:0]  s_gnt0;
  logic [7:0]  s_rdata_last;

  task automatic capture(input int idx);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i == 0) s_gnt0 = gnt;
      s_wr[i] = wr; s_ad[i] = ad; s_cs[i] = cs; s_rd[i] = rd; s_oe[i] = ad_oe;
      s_dn[i] = done[idx]; s_out[i] = ADout;
    end
    s_rdata_last = rdata;
  endtask

  task automatic wait_any_done(output int idx, output int c, output bit ok);
    ok = 0; idx = -1; c = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (done != '0) begin
        ok = 1; c = cyc;
        for (int k = 0; k < NREQ; k++) if (done[k]) idx = k;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global-timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5], dcyc[5], exp_order[5];
    int di, dc, c0, na, nd;
    bit ok;
    logic [6:0] v_wr, v_ad, v_cs, v_dn, v_bz;

`ifdef RTC_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif

    repeat (3) @(negedge clock);
    check("reset state", {gnt, done, rdata, busy, ADout, ad_oe, ad, wr, rd, cs},
          {4'h0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 4'b1111});
    reset = 1'b0;
    @(negedge clock);

    // All requesters held: grant order and done spacing.
    rw = '0; rtc_byte = 8'h3C; req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_any_done(order[t], dcyc[t], ok);
      check("rr done seen", 32'(ok), 32'd1);
    end
    req = '0;
    for (int t = 0; t < 5; t++) check($sformatf("rr order %0d", t), order[t], exp_order[t]);
    for (int t = 1; t < 5; t++) check($sformatf("rr gap %0d", t), dcyc[t] - dcyc[t-1], 17);
    @(negedge clock);

    // Single write from requester 2.
    rw[2] = 1'b1; addr[23:16] = 8'h21; wdata[23:16] = 8'h45; req[2] = 1'b1;
    capture(2);
    req[2] = 1'b0;
    $display("write req2 addr=21 wdata=45 gnt0=%b", s_gnt0);
    check("wr gnt", s_gnt0, 4'b0100);
    check("wr wr pattern", s_wr, 16'hF0F0);
    check("wr ad pattern", s_ad, 16'hFF00);
    check("wr cs pattern", s_cs, 16'hF000);
    check("wr done pattern", s_dn, 16'h8000);
    na = 0; nd = 0;
    for (int i = 0; i < 8; i++) if (s_out[i] == 8'h21) na++;
    for (int i = 8; i < 12; i++) if (s_out[i] == 8'h45) nd++;
    check("wr addr cycles", na, 8);
    check("wr data cycles", nd, 4);
    @(negedge clock);

    // Single read from requester 1.
    rw[1] = 1'b0; addr[15:8] = 8'h23; rtc_byte = 8'h59; req[1] = 1'b1;
    capture(1);
    req[1] = 1'b0;
    $display("read req1 addr=23 rdata=%h", s_rdata_last);
    check("rd gnt", s_gnt0, 4'b0010);
    check("rd rd pattern", s_rd, 16'hF0FF);
    check("rd oe pattern", s_oe, 16'h00FF);
    check("rd wr pattern", s_wr, 16'hFFF0);
    check("rd done pattern", s_dn, 16'h8000);
    check("rd rdata", s_rdata_last, 8'h59);
    @(negedge clock);

    // Requester 3 drops req during ADDR; the transaction still completes.
    rw[3] = 1'b1; addr[31:24] = 8'h2A; wdata[31:24] = 8'h77; req[3] = 1'b1;
    @(negedge clock);
    c0 = cyc;
    check("drop gnt", gnt, 4'b1000);
    @(negedge clock);
    req[3] = 1'b0;
    wait_any_done(di, dc, ok);
    $display("drop req3 done idx=%0d at +%0d", di, dc - c0);
    check("drop done seen", 32'(ok), 32'd1);
    check("drop done idx", di, 3);
    check("drop done cycle", dc - c0, 15);
    @(negedge clock);
    check("drop idle after", {gnt, busy}, 5'b0);

    // Reset during the DATA phase of a write from requester 0.
    rw[0] = 1'b1; addr[7:0] = 8'h10; wdata[7:0] = 8'h99; req[0] = 1'b1;
    repeat (10) @(negedge clock);
    check("rst in data", {cs, ad, wr}, 3'b010);
    reset = 1'b1;
    #1;
    check("rst strobes", {cs, ad, wr, rd, ad_oe}, 5'b11110);
    check("rst gnt", {gnt, busy, done}, 9'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    c0 = cyc;
    check("rst regrant", gnt, 4'b0001);
    wait_any_done(di, dc, ok);
    req[0] = 1'b0;
    $display("reset regrant done idx=%0d at +%0d", di, dc - c0);
    check("rst done seen", 32'(ok), 32'd1);
    check("rst done idx", di, 0);
    check("rst done cycle", dc - c0, 15);
    @(negedge clock);

    // Short phases: TPH=1, TREC=2.
    rw2[1] = 1'b1; addr2[15:8] = 8'h30; wdata2[15:8] = 8'h0F; req2[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      v_wr[i] = wr2; v_ad[i] = ad2; v_cs[i] = cs2; v_dn[i] = done2[1]; v_bz[i] = (gnt2 != '0);
      if (i == 4) req2[1] = 1'b0;
    end
    $display("short-phase write wr=%b ad=%b cs=%b done=%b gnt=%b", v_wr, v_ad, v_cs, v_dn, v_bz);
    check("tph1 wr", v_wr, 7'b1111010);
    check("tph1 ad", v_ad, 7'b1111100);
    check("tph1 cs", v_cs, 7'b1111000);
    check("tph1 done", v_dn, 7'b0010000);
    check("tph1 gnt span", v_bz, 7'b0011111);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
